// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-meter test-signal source: mode
// encodings, default timing constants and the half-period lookup.
package freq_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_100HZ = 2'b00;
    localparam mode_t MODE_10KHZ = 2'b01;
    localparam mode_t MODE_1MHZ  = 2'b10;
    localparam mode_t MODE_5MHZ  = 2'b11;

    // Default half-periods in sysclk cycles for a 50 MHz system clock.
    localparam int unsigned DEF_HALF0       = 250000;
    localparam int unsigned DEF_HALF1       = 2500;
    localparam int unsigned DEF_HALF2       = 25;
    localparam int unsigned DEF_HALF3       = 5;
    localparam int unsigned DEF_GATE_CYCLES = 50000000;
    localparam int          DEF_CNT_W       = 24;

    // Half-period for a mode; the caller passes its own (possibly overridden)
    // table so the package never has to know the instance parameters.
    function automatic int unsigned half_of(input mode_t mode,
                                            input int unsigned h0,
                                            input int unsigned h1,
                                            input int unsigned h2,
                                            input int unsigned h3);
        case (mode)
            MODE_100HZ: return h0;
            MODE_10KHZ: return h1;
            MODE_1MHZ:  return h2;
            default:    return h3;
        endcase
    endfunction

endpackage

// File: rtl/test_sig_gen_if.sv
// Bundle of the test-signal source's control and status lines. The master
// side drives enable, mode and gate start; the slave side is the generator.
interface test_sig_gen_if
    import freq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             en;
    mode_t            testmode;
    logic             gate_start;
    logic             sigin;
    mode_t            mode_act;
    logic             gate_busy;
    logic [CNT_W-1:0] ref_count;
    logic             ref_valid;

    modport master (
        output en, testmode, gate_start,
        input  sigin, mode_act, gate_busy, ref_count, ref_valid
    );

    modport slave (
        input  en, testmode, gate_start,
        output sigin, mode_act, gate_busy, ref_count, ref_valid
    );

endinterface

// File: rtl/gate_counter.sv
// Reference gate: opens a window of GATE_CYCLES cycles on a start pulse and
// counts rising edges of the test signal inside it, saturating at all-ones.
module gate_counter
    import freq_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             start,
    input  logic             rise,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             valid
);

    localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_next;

    // Edge count including this cycle's rise, held at full scale instead of wrapping.
    always_comb begin
        edge_next = edge_cnt;
        if (rise && (edge_cnt != CNT_MAX)) begin
            edge_next = edge_cnt + CNT_W'(1);
        end
    end

    // Window timing and result capture; a start while busy is simply not looked at.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            win_cnt  <= '0;
            edge_cnt <= '0;
            count    <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    win_cnt  <= WIN_W'(GATE_CYCLES - 1);
                    edge_cnt <= '0;
                end
            end else begin
                edge_cnt <= edge_next;
                if (win_cnt == '0) begin
                    busy  <= 1'b0;
                    count <= edge_next;
                    valid <= 1'b1;
                end else begin
                    win_cnt <= win_cnt - WIN_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/test_sig_gen.sv
// On-chip test-signal source: a glitch-free 50% square wave at one of four
// frequencies on sigin, plus a gated reference count of its own rising edges.
module test_sig_gen
    import freq_pkg::*;
#(
    parameter int unsigned HALF0       = DEF_HALF0,
    parameter int unsigned HALF1       = DEF_HALF1,
    parameter int unsigned HALF2       = DEF_HALF2,
    parameter int unsigned HALF3       = DEF_HALF3,
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input logic           sysclk,
    input logic           reset,
    test_sig_gen_if.slave bus
);

    localparam int unsigned MAX01    = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int unsigned MAX23    = (HALF2 > HALF3) ? HALF2 : HALF3;
    localparam int unsigned HALF_MAX = (MAX01 > MAX23) ? MAX01 : MAX23;
    localparam int          HALF_W   = (HALF_MAX > 2) ? $clog2(HALF_MAX) : 1;

    mode_t             tm_m;
    mode_t             tm_s;
    logic [2:0]        warm;
    logic [HALF_W-1:0] cnt;
    logic [HALF_W-1:0] half_load;
    logic              sigin_q;
    logic              sigin_d;
    mode_t             mode_q;
    logic              go;
    logic              idle;
    logic              rise;

    // The generator may only leave idle once the synchronizer carries a real
    // switch value, otherwise the first level would use the cleared mode.
    assign go        = bus.en & warm[2];
    assign idle      = ~sigin_q & ~go;
    assign half_load = HALF_W'(half_of(tm_s, HALF0, HALF1, HALF2, HALF3) - 1);
    assign rise      = sigin_q & ~sigin_d;

    // Two-flop synchronizer for the mode switches plus its warm-up shift.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tm_m <= MODE_100HZ;
            tm_s <= MODE_100HZ;
            warm <= '0;
        end else begin
            tm_m <= bus.testmode;
            tm_s <= tm_m;
            warm <= {warm[1:0], 1'b1};
        end
    end

    // Half-period counter and sigin register; mode and enable only act at level boundaries.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            sigin_q <= 1'b0;
            sigin_d <= 1'b0;
            mode_q  <= MODE_100HZ;
        end else begin
            sigin_d <= sigin_q;
            if (idle) begin
                cnt    <= half_load;
                mode_q <= tm_s;
            end else if (cnt == '0) begin
                sigin_q <= ~sigin_q;
                mode_q  <= tm_s;
                cnt     <= half_load;
            end else begin
                cnt <= cnt - HALF_W'(1);
            end
        end
    end

    assign bus.sigin    = sigin_q;
    assign bus.mode_act = mode_q;

    gate_counter #(
        .GATE_CYCLES (GATE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_gate (
        .sysclk (sysclk),
        .reset  (reset),
        .start  (bus.gate_start),
        .rise   (rise),
        .busy   (bus.gate_busy),
        .count  (bus.ref_count),
        .valid  (bus.ref_valid)
    );

endmodule

// File: tb/tb_test_sig_gen.sv
// Directed bench for test_sig_gen: square-wave timing, glitch-free mode
// change, enable handling, reference gate, reset mid-gate and saturation.
module tb_test_sig_gen;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   len;
    int   n;
    int   busy_cycles;
    int   rises;
    int   valids;
    int   highs;
    logic prev;

    test_sig_gen_if #(.CNT_W(24)) bus ();
    test_sig_gen_if #(.CNT_W(4))  bus4 ();

    test_sig_gen #(.GATE_CYCLES(1000), .CNT_W(24)) dut (
        .sysclk (clk),
        .reset  (reset),
        .bus    (bus)
    );

    test_sig_gen #(.GATE_CYCLES(1000), .CNT_W(4)) dut4 (
        .sysclk (clk),
        .reset  (reset),
        .bus    (bus4)
    );

    // 20 ns clock; posedges at 20, 40, ... so a 50 ns reset release lands on a negedge.
    initial begin
        clk = 1'b1;
        forever #10 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input logic lvl, input int budget, input string tag);
        int k = 0;
        while (bus.sigin !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output(tag, 32'(bus.sigin), 32'(lvl));
    endtask

    task automatic wait_rise(input string tag);
        wait_for(1'b0, 60, tag);
        wait_for(1'b1, 60, tag);
    endtask

    // Called on the first negedge showing lvl; returns on the first negedge that does not.
    task automatic measure(input logic lvl, input int tm_at, input logic [1:0] tm_val,
                           input int en_at, input logic en_val, output int length);
        int guard = 0;
        length = 1;
        while (guard < 1000) begin
            if (length == tm_at) bus.testmode = tm_val;
            if (length == en_at) bus.en = en_val;
            @(negedge clk);
            if (bus.sigin !== lvl) break;
            length++;
            guard++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.en = 1'b1;  bus.testmode = 2'b11;  bus.gate_start = 1'b0;
        bus4.en = 1'b1; bus4.testmode = 2'b11; bus4.gate_start = 1'b0;

        // 1: reset values, then 5 MHz period
        #25;
        check_output("rst_sigin", 32'(bus.sigin), 32'd0);
        check_output("rst_mode_act", 32'(bus.mode_act), 32'd0);
        check_output("rst_gate_busy", 32'(bus.gate_busy), 32'd0);
        check_output("rst_ref_count", 32'(bus.ref_count), 32'd0);
        check_output("rst_ref_valid", 32'(bus.ref_valid), 32'd0);
        #25;
        reset = 1'b0;
        $display("[TB] test 1: mode 11 after reset");
        wait_rise("t1_first_rise");
        measure(1'b1, 0, 2'b11, 0, 1'b1, len);
        check_output("t1_high", 32'(len), 32'd5);
        measure(1'b0, 0, 2'b11, 0, 1'b1, len);
        check_output("t1_low", 32'(len), 32'd5);
        check_output("t1_mode_act", 32'(bus.mode_act), 32'd3);

        // 2: mode 10, then switch to 11 mid-high
        $display("[TB] test 2: mode change");
        bus.testmode = 2'b10;
        repeat (12) @(negedge clk);
        wait_rise("t2_rise");
        measure(1'b1, 0, 2'b10, 0, 1'b1, len);
        check_output("t2_high_m10", 32'(len), 32'd25);
        check_output("t2_mode_act_m10", 32'(bus.mode_act), 32'd2);
        measure(1'b0, 0, 2'b10, 0, 1'b1, len);
        check_output("t2_low_m10", 32'(len), 32'd25);
        measure(1'b1, 5, 2'b11, 0, 1'b1, len);
        check_output("t2_switch_level", 32'(len), 32'd25);
        measure(1'b0, 0, 2'b11, 0, 1'b1, len);
        check_output("t2_low_after", 32'(len), 32'd5);
        measure(1'b1, 0, 2'b11, 0, 1'b1, len);
        check_output("t2_high_after", 32'(len), 32'd5);
        check_output("t2_mode_act_m11", 32'(bus.mode_act), 32'd3);

        // 3: gate window, 100 rises in 1000 cycles, back-to-back restart
        $display("[TB] test 3: reference gate");
        prev = bus.sigin;
        bus.gate_start = 1'b1;
        @(negedge clk);
        bus.gate_start = 1'b0;
        check_output("t3_busy_start", 32'(bus.gate_busy), 32'd1);
        busy_cycles = 0;
        rises = 0;
        while (bus.gate_busy === 1'b1 && busy_cycles < 1100) begin
            busy_cycles++;
            if (bus.sigin === 1'b1 && prev === 1'b0) rises++;
            prev = bus.sigin;
            @(negedge clk);
        end
        check_output("t3_busy_len", 32'(busy_cycles), 32'd1000);
        check_output("t3_valid", 32'(bus.ref_valid), 32'd1);
        check_output("t3_count_model", 32'(bus.ref_count), 32'(rises));
        check_output("t3_count", 32'(bus.ref_count), 32'd100);
        bus.gate_start = 1'b1;
        @(negedge clk);
        bus.gate_start = 1'b0;
        check_output("t3_valid_one_cycle", 32'(bus.ref_valid), 32'd0);
        check_output("t3_restart_busy", 32'(bus.gate_busy), 32'd1);
        n = 0;
        while (bus.ref_valid !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check_output("t3_second_valid", 32'(bus.ref_valid), 32'd1);
        check_output("t3_second_count", 32'(bus.ref_count), 32'd100);

        // 4: disable two cycles into a high level, then re-enable
        $display("[TB] test 4: enable control");
        wait_rise("t4_rise");
        measure(1'b1, 0, 2'b11, 2, 1'b0, len);
        check_output("t4_high_full", 32'(len), 32'd5);
        highs = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sigin !== 1'b0) highs++;
        end
        check_output("t4_idle_low", 32'(highs), 32'd0);
        bus.en = 1'b1;
        n = 0;
        while (bus.sigin !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("t4_restart_delay", 32'(n), 32'd5);
        measure(1'b1, 0, 2'b11, 0, 1'b1, len);
        check_output("t4_high_after", 32'(len), 32'd5);

        // 5: reset half way through a gate
        $display("[TB] test 5: reset mid-gate");
        bus.gate_start = 1'b1;
        @(negedge clk);
        bus.gate_start = 1'b0;
        repeat (499) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("t5_busy", 32'(bus.gate_busy), 32'd0);
        check_output("t5_ref_count", 32'(bus.ref_count), 32'd0);
        check_output("t5_sigin", 32'(bus.sigin), 32'd0);
        check_output("t5_mode_act", 32'(bus.mode_act), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        valids = 0;
        busy_cycles = 0;
        repeat (1100) begin
            @(negedge clk);
            if (bus.ref_valid !== 1'b0) valids++;
            if (bus.gate_busy !== 1'b0) busy_cycles++;
        end
        check_output("t5_no_valid", 32'(valids), 32'd0);
        check_output("t5_no_busy", 32'(busy_cycles), 32'd0);

        // 6: 4-bit counter saturates; start while busy does not move the window end
        $display("[TB] test 6: saturation and busy start");
        bus4.gate_start = 1'b1;
        @(negedge clk);
        bus4.gate_start = 1'b0;
        busy_cycles = 0;
        while (bus4.gate_busy === 1'b1 && busy_cycles < 1500) begin
            busy_cycles++;
            bus4.gate_start = (busy_cycles == 300);
            @(negedge clk);
        end
        bus4.gate_start = 1'b0;
        check_output("t6_busy_len", 32'(busy_cycles), 32'd1000);
        check_output("t6_valid", 32'(bus4.ref_valid), 32'd1);
        check_output("t6_saturated", 32'(bus4.ref_count), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
